// File: rtl/task_dispatcher_pkg.sv
// Shared types and control-frame layout for the task dispatcher.
// Field offsets are functions so every file derives the same layout from the core/R0/IFN widths.
package task_dispatcher_pkg;

    typedef enum logic [1:0] {
        FENCE_NO  = 2'd0,
        FENCE_ACQ = 2'd1,
        FENCE_REL = 2'd2,
        FENCE_ILL = 2'd3
    } fence_e;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_FENCE_WAIT,
        ST_IF_FETCH,
        ST_LOAD,
        ST_DONE_WAIT,
        ST_SYNC
    } state_e;

    localparam int FENCE_W     = 2;
    localparam int STOP_ADDR_W = 16;

    // Layout from bit 0 upward: ifn, fence, core_mask, init_r0_vect, init_r0, stop, stop_addr.
    function automatic int cf_ifn_lsb();
        return 0;
    endfunction

    function automatic int cf_fence_lsb(input int ifn_w);
        return ifn_w;
    endfunction

    function automatic int cf_mask_lsb(input int ifn_w);
        return ifn_w + FENCE_W;
    endfunction

    function automatic int cf_r0v_lsb(input int num_cores, input int ifn_w);
        return ifn_w + FENCE_W + num_cores;
    endfunction

    function automatic int cf_r0_lsb(input int num_cores, input int ifn_w);
        return ifn_w + FENCE_W + 2 * num_cores;
    endfunction

    function automatic int cf_stop_lsb(input int num_cores, input int r0_w, input int ifn_w);
        return ifn_w + FENCE_W + 2 * num_cores + num_cores * r0_w;
    endfunction

    function automatic int cf_saddr_lsb(input int num_cores, input int r0_w, input int ifn_w);
        return cf_stop_lsb(num_cores, r0_w, ifn_w) + 1;
    endfunction

    function automatic int cf_width(input int num_cores, input int r0_w, input int ifn_w);
        return cf_saddr_lsb(num_cores, r0_w, ifn_w) + STOP_ADDR_W;
    endfunction

endpackage

// File: rtl/task_dispatcher_if.sv
// Bus between the dispatcher (master) and its task memory, cores and display sync (slave).
interface task_dispatcher_if #(
    parameter int NUM_CORES  = 16,
    parameter int TM_DEPTH   = 64,
    parameter int LOAD_BEATS = 4,
    parameter int INSN_W     = 64,
    parameter int R0_W       = 8
);
    logic                            enable;
    logic [$clog2(TM_DEPTH)-1:0]     tm_addr;
    logic [LOAD_BEATS*INSN_W-1:0]    tm_data;
    logic [NUM_CORES-1:0]            ready;
    logic [NUM_CORES-1:0]            start;
    logic [$clog2(LOAD_BEATS)-1:0]   load_cnt;
    logic [INSN_W-1:0]               insn_data;
    logic [NUM_CORES-1:0]            init_r0_vect;
    logic [NUM_CORES*R0_W-1:0]       init_r0;
    logic                            frame_req;
    logic                            frame_ack;
    logic                            busy;
    logic                            err;

    modport master (
        input  enable, tm_data, ready, frame_ack,
        output tm_addr, start, load_cnt, insn_data, init_r0_vect, init_r0,
               frame_req, busy, err
    );

    modport slave (
        output enable, tm_data, ready, frame_ack,
        input  tm_addr, start, load_cnt, insn_data, init_r0_vect, init_r0,
               frame_req, busy, err
    );
endinterface

// File: rtl/task_dispatcher_cf_decode.sv
// Purely combinational split of a control frame into its named fields.
module td_cf_decode
    import task_dispatcher_pkg::*;
#(
    parameter int NUM_CORES = 16,
    parameter int R0_W      = 8,
    parameter int IFN_W     = 8,
    parameter int CF_W      = cf_width(NUM_CORES, R0_W, IFN_W)
) (
    input  logic [CF_W-1:0]             cf,
    output logic [IFN_W-1:0]            ifn,
    output logic [FENCE_W-1:0]          fence_raw,
    output logic [NUM_CORES-1:0]        core_mask,
    output logic [NUM_CORES-1:0]        init_r0_vect,
    output logic [NUM_CORES*R0_W-1:0]   init_r0,
    output logic                        stop,
    output logic [STOP_ADDR_W-1:0]      stop_addr
);
    localparam int L_IFN   = cf_ifn_lsb();
    localparam int L_FENCE = cf_fence_lsb(IFN_W);
    localparam int L_MASK  = cf_mask_lsb(IFN_W);
    localparam int L_R0V   = cf_r0v_lsb(NUM_CORES, IFN_W);
    localparam int L_R0    = cf_r0_lsb(NUM_CORES, IFN_W);
    localparam int L_STOP  = cf_stop_lsb(NUM_CORES, R0_W, IFN_W);
    localparam int L_SADDR = cf_saddr_lsb(NUM_CORES, R0_W, IFN_W);

    assign ifn          = cf[L_IFN   +: IFN_W];
    assign fence_raw    = cf[L_FENCE +: FENCE_W];
    assign core_mask    = cf[L_MASK  +: NUM_CORES];
    assign init_r0_vect = cf[L_R0V   +: NUM_CORES];
    assign init_r0      = cf[L_R0    +: NUM_CORES*R0_W];
    assign stop         = cf[L_STOP];
    assign stop_addr    = cf[L_SADDR +: STOP_ADDR_W];
endmodule

// File: rtl/task_dispatcher.sv
// Walks task memory: a control frame sets fence/mask/count, then instruction frames are
// streamed beat by beat to the masked cores, optionally followed by a display-sync handshake.
module task_dispatcher
    import task_dispatcher_pkg::*;
#(
    parameter int NUM_CORES  = 16,
    parameter int TM_DEPTH   = 64,
    parameter int LOAD_BEATS = 4,
    parameter int INSN_W     = 64,
    parameter int R0_W       = 8,
    parameter int IFN_W      = 8
) (
    input  logic               clk,
    input  logic               reset,
    task_dispatcher_if.master  bus
);
    localparam int PTR_W = $clog2(TM_DEPTH);
    localparam int LC_W  = $clog2(LOAD_BEATS);
    localparam int CF_W  = cf_width(NUM_CORES, R0_W, IFN_W);

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(TM_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [PTR_W-1:0] wrap_addr(input logic [STOP_ADDR_W-1:0] a);
        int v;
        v = int'(a) % TM_DEPTH;
        return PTR_W'(v);
    endfunction

    logic [IFN_W-1:0]            cf_ifn;
    logic [FENCE_W-1:0]          cf_fence;
    logic [NUM_CORES-1:0]        cf_mask;
    logic [NUM_CORES-1:0]        cf_r0v;
    logic [NUM_CORES*R0_W-1:0]   cf_r0;
    logic                        cf_stop;
    logic [STOP_ADDR_W-1:0]      cf_saddr;

    td_cf_decode #(
        .NUM_CORES (NUM_CORES),
        .R0_W      (R0_W),
        .IFN_W     (IFN_W)
    ) u_cf_decode (
        .cf           (bus.tm_data[CF_W-1:0]),
        .ifn          (cf_ifn),
        .fence_raw    (cf_fence),
        .core_mask    (cf_mask),
        .init_r0_vect (cf_r0v),
        .init_r0      (cf_r0),
        .stop         (cf_stop),
        .stop_addr    (cf_saddr)
    );

    state_e                      state_q, state_d;
    logic [PTR_W-1:0]            ptr_q, ptr_d;
    logic [IFN_W-1:0]            ifn_q, ifn_d;
    fence_e                      fence_q, fence_d;
    logic [NUM_CORES-1:0]        mask_q, mask_d;
    logic [NUM_CORES-1:0]        r0v_q, r0v_d;
    logic [NUM_CORES*R0_W-1:0]   r0_q, r0_d;
    logic                        stop_q, stop_d;
    logic [PTR_W-1:0]            saddr_q, saddr_d;
    logic                        dw_first_q, dw_first_d;
    logic [NUM_CORES-1:0]        start_q, start_d;
    logic [LC_W-1:0]             load_cnt_q, load_cnt_d;
    logic                        frame_req_q, frame_req_d;
    logic                        busy_q, busy_d;
    logic                        err_q, err_d;

    logic all_rdy;
    logic mask_idle;

    assign all_rdy   = &bus.ready;
    assign mask_idle = ((~bus.ready) & mask_q) == '0;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        ifn_d       = ifn_q;
        fence_d     = fence_q;
        mask_d      = mask_q;
        r0v_d       = r0v_q;
        r0_d        = r0_q;
        stop_d      = stop_q;
        saddr_d     = saddr_q;
        dw_first_d  = 1'b0;
        start_d     = '0;
        load_cnt_d  = '0;
        frame_req_d = frame_req_q;
        err_d       = err_q;

        case (state_q)
            ST_FETCH: begin
                if (bus.enable) state_d = ST_DECODE;
            end
            ST_DECODE: begin
                // An illegal fence code runs as an unfenced group but is remembered in err.
                ifn_d   = cf_ifn;
                fence_d = (cf_fence == FENCE_ILL) ? FENCE_NO : fence_e'(cf_fence);
                err_d   = err_q | (cf_fence == FENCE_ILL);
                mask_d  = cf_mask;
                r0v_d   = cf_r0v;
                r0_d    = cf_r0;
                stop_d  = cf_stop;
                saddr_d = wrap_addr(cf_saddr);
                state_d = ST_FENCE_WAIT;
            end
            ST_FENCE_WAIT: begin
                if ((fence_q == FENCE_NO) ? mask_idle : all_rdy) begin
                    ptr_d = next_ptr(ptr_q);
                    if (ifn_q != '0)  state_d = ST_IF_FETCH;
                    else if (stop_q)  state_d = ST_SYNC;
                    else              state_d = ST_FETCH;
                end
            end
            ST_IF_FETCH: begin
                state_d    = ST_LOAD;
                start_d    = mask_q;
                load_cnt_d = '0;
            end
            ST_LOAD: begin
                if (load_cnt_q == LC_W'(LOAD_BEATS - 1)) begin
                    ptr_d      = next_ptr(ptr_q);
                    ifn_d      = ifn_q - 1'b1;
                    dw_first_d = 1'b1;
                    state_d    = ST_DONE_WAIT;
                end else begin
                    start_d    = mask_q;
                    load_cnt_d = load_cnt_q + 1'b1;
                end
            end
            ST_DONE_WAIT: begin
                // Cores only drop ready a cycle after the last start, so the first cycle is blind.
                if (!dw_first_q && mask_idle) begin
                    if (ifn_q != '0)                         state_d = ST_IF_FETCH;
                    else if (stop_q || fence_q == FENCE_REL) state_d = ST_SYNC;
                    else                                     state_d = ST_FETCH;
                end
            end
            ST_SYNC: begin
                if (stop_q) begin
                    if (frame_req_q) begin
                        if (bus.frame_ack) begin
                            frame_req_d = 1'b0;
                            ptr_d       = saddr_q;
                            state_d     = ST_FETCH;
                        end
                    end else if (all_rdy) begin
                        frame_req_d = 1'b1;
                    end
                end else if (all_rdy) begin
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_FETCH;
        endcase

        busy_d = (state_d != ST_FETCH);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_FETCH;
            ptr_q       <= '0;
            ifn_q       <= '0;
            fence_q     <= FENCE_NO;
            mask_q      <= '0;
            r0v_q       <= '0;
            r0_q        <= '0;
            stop_q      <= 1'b0;
            saddr_q     <= '0;
            dw_first_q  <= 1'b0;
            start_q     <= '0;
            load_cnt_q  <= '0;
            frame_req_q <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            ifn_q       <= ifn_d;
            fence_q     <= fence_d;
            mask_q      <= mask_d;
            r0v_q       <= r0v_d;
            r0_q        <= r0_d;
            stop_q      <= stop_d;
            saddr_q     <= saddr_d;
            dw_first_q  <= dw_first_d;
            start_q     <= start_d;
            load_cnt_q  <= load_cnt_d;
            frame_req_q <= frame_req_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    // Frame data only arrives in the beat's own cycle, so the payload is a mux, not a flop.
    always_comb begin
        bus.insn_data = '0;
        if (state_q == ST_LOAD) bus.insn_data = bus.tm_data[int'(load_cnt_q)*INSN_W +: INSN_W];
    end

    assign bus.tm_addr      = ptr_q;
    assign bus.start        = start_q;
    assign bus.load_cnt     = load_cnt_q;
    assign bus.init_r0_vect = r0v_q;
    assign bus.init_r0      = r0_q;
    assign bus.frame_req    = frame_req_q;
    assign bus.busy         = busy_q;
    assign bus.err          = err_q;
endmodule

// File: tb/tb_task_dispatcher.sv
// Bench for task_dispatcher: table of task groups plus hand sequences for fence, sync, wrap and reset.
module tb_task_dispatcher;
    localparam int NC  = 16;
    localparam int TMD = 64;
    localparam int LB  = 4;
    localparam int IW  = 64;
    localparam int RW  = 8;
    localparam int IFW = 8;
    localparam int FW  = LB * IW;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    task_dispatcher_if #(.NUM_CORES(NC), .TM_DEPTH(TMD), .LOAD_BEATS(LB), .INSN_W(IW), .R0_W(RW)) bus ();

    task_dispatcher #(
        .NUM_CORES(NC), .TM_DEPTH(TMD), .LOAD_BEATS(LB), .INSN_W(IW), .R0_W(RW), .IFN_W(IFW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [FW-1:0] mem [TMD];
    always @(posedge clk) bus.tm_data <= mem[bus.tm_addr];

    typedef struct {
        logic [NC-1:0] start;
        logic [1:0]    lc;
        logic [IW-1:0] insn;
    } beat_t;
    beat_t sb[$];

    int n_run  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        beat_t e;
        if (bus.start !== '0) begin
            if (sb.size() == 0) begin
                check("unexpected_start", 256'(bus.start), 256'(0));
            end else begin
                e = sb.pop_front();
                check("start", 256'(bus.start), 256'(e.start));
                check("load_cnt", 256'(bus.load_cnt), 256'(e.lc));
                check("insn_data", 256'(bus.insn_data), 256'(e.insn));
            end
        end
    end

    // Control frame: ifn[7:0] fence[9:8] mask[25:10] r0v[41:26] r0[169:42] stop[170] saddr[186:171]
    function automatic logic [FW-1:0] mk_cf(input logic [7:0] ifn, input logic [1:0] fence,
                                             input logic [15:0] mask, input logic [15:0] r0v,
                                             input logic [127:0] r0, input logic stop,
                                             input logic [15:0] saddr);
        logic [FW-1:0] f;
        f          = '0;
        f[7:0]     = ifn;
        f[9:8]     = fence;
        f[25:10]   = mask;
        f[41:26]   = r0v;
        f[169:42]  = r0;
        f[170]     = stop;
        f[186:171] = saddr;
        return f;
    endfunction

    function automatic logic [FW-1:0] rand_frame();
        logic [FW-1:0] f;
        for (int i = 0; i < FW / 32; i++) f[i*32 +: 32] = $urandom;
        return f;
    endfunction

    task automatic load_group(input int at, input logic [1:0] fence, input logic [15:0] mask,
                              input int ifn, input logic [15:0] r0v, input logic [127:0] r0,
                              input logic stop, input logic [15:0] saddr);
        beat_t b;
        int    a;
        mem[at] = mk_cf(8'(ifn), fence, mask, r0v, r0, stop, saddr);
        for (int k = 1; k <= ifn; k++) begin
            a      = (at + k) % TMD;
            mem[a] = rand_frame();
            for (int j = 0; j < LB; j++) begin
                b.start = mask;
                b.lc    = 2'(j);
                b.insn  = mem[a][j*IW +: IW];
                sb.push_back(b);
            end
        end
    endtask

    task automatic go();
        @(negedge clk) bus.enable = 1'b1;
        @(negedge clk) bus.enable = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int max);
        bit done;
        done = 1'b0;
        for (int k = 0; k < max && !done; k++) begin
            @(negedge clk);
            if (!bus.busy) done = 1'b1;
        end
        check({name, "_idle"}, 256'(done), 256'(1));
    endtask

    task automatic wait_req(input string name, input int max);
        bit done;
        done = 1'b0;
        for (int k = 0; k < max && !done; k++) begin
            @(negedge clk);
            if (bus.frame_req) done = 1'b1;
        end
        check({name, "_req"}, 256'(done), 256'(1));
    endtask

    task automatic pulse_ack();
        bus.frame_ack = 1'b1;
        @(negedge clk) bus.frame_ack = 1'b0;
    endtask

    typedef struct {
        logic [1:0]   fence;
        logic [15:0]  mask;
        int           ifn;
        logic [15:0]  r0v;
        logic [127:0] r0;
        int           exp_ptr;
        logic         exp_err;
    } vec_t;
    vec_t tbl[6];

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not reach summary");
        $fatal(1, "timeout");
    end

    initial begin
        int  at;
        bit  found;

        tbl[0] = '{2'd0, 16'h0003, 2, 16'h0003, {16{8'h11}},  3, 1'b0};
        tbl[1] = '{2'd1, 16'h00F0, 1, 16'h00A0, {16{8'h22}},  5, 1'b0};
        tbl[2] = '{2'd2, 16'h8001, 1, 16'h8000, {16{8'h33}},  7, 1'b0};
        tbl[3] = '{2'd3, 16'h0004, 1, 16'h0004, {16{8'h44}},  9, 1'b1};
        tbl[4] = '{2'd0, 16'hFFFF, 0, 16'hFFFF, {16{8'h55}}, 10, 1'b1};
        tbl[5] = '{2'd0, 16'h0010, 3, 16'h0010, {16{8'h66}}, 14, 1'b1};

        for (int i = 0; i < TMD; i++) mem[i] = '0;
        reset         = 1'b1;
        bus.enable    = 1'b0;
        bus.ready     = 16'hFFFF;
        bus.frame_ack = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tm_addr", 256'(bus.tm_addr), 256'(0));
        check("rst_start", 256'({bus.start, bus.load_cnt, bus.insn_data}), 256'(0));
        check("rst_r0", 256'({bus.init_r0_vect, bus.init_r0}), 256'(0));
        check("rst_flags", 256'({bus.frame_req, bus.busy, bus.err}), 256'(0));
        reset = 1'b0;
        @(negedge clk);

        at = 0;
        for (int i = 0; i < 6; i++) begin
            load_group(at, tbl[i].fence, tbl[i].mask, tbl[i].ifn, tbl[i].r0v, tbl[i].r0, 1'b0, 16'd0);
            go();
            wait_idle($sformatf("vec%0d", i), 100);
            check($sformatf("vec%0d_ptr", i), 256'(bus.tm_addr), 256'(tbl[i].exp_ptr));
            check($sformatf("vec%0d_err", i), 256'(bus.err), 256'(tbl[i].exp_err));
            check($sformatf("vec%0d_r0v", i), 256'(bus.init_r0_vect), 256'(tbl[i].r0v));
            check($sformatf("vec%0d_r0", i), 256'(bus.init_r0), 256'(tbl[i].r0));
            check($sformatf("vec%0d_sb", i), 256'(sb.size()), 256'(0));
            at = tbl[i].exp_ptr;
        end

        // ACQ fence held off by core 0, load starts two cycles after it frees up
        bus.ready = 16'hFFFE;
        load_group(14, 2'd1, 16'h0001, 1, 16'h0, 128'h0, 1'b0, 16'd0);
        go();
        repeat (6) @(negedge clk);
        check("acq_blocked", 256'({bus.busy, bus.start}), 256'({1'b1, 16'h0000}));
        bus.ready = 16'hFFFF;
        @(negedge clk);
        check("acq_gap", 256'(bus.start), 256'(0));
        @(negedge clk);
        check("acq_start", 256'(bus.start), 256'(16'h0001));
        wait_idle("acq", 50);
        check("acq_ptr", 256'(bus.tm_addr), 256'(16));

        // Stop with display sync, ack outside SYNC ignored
        bus.ready = 16'h7FFF;
        load_group(16, 2'd0, 16'h0002, 1, 16'h0, 128'h0, 1'b1, 16'd5);
        go();
        pulse_ack();
        for (int k = 0; k < 30 && sb.size() != 0; k++) @(negedge clk);
        repeat (5) @(negedge clk);
        check("sync_wait_idle", 256'({bus.busy, bus.frame_req}), 256'({1'b1, 1'b0}));
        bus.ready = 16'hFFFF;
        wait_req("sync", 5);
        repeat (10) @(negedge clk);
        check("sync_req_held", 256'({bus.busy, bus.frame_req}), 256'({1'b1, 1'b1}));
        pulse_ack();
        check("sync_done", 256'({bus.busy, bus.frame_req}), 256'(0));
        check("sync_stop_addr", 256'(bus.tm_addr), 256'(5));

        // stop_addr beyond depth lands on the last entry, which then wraps to 0
        load_group(5, 2'd0, 16'h0000, 0, 16'h0, 128'h0, 1'b1, 16'd127);
        go();
        wait_req("wrap", 20);
        pulse_ack();
        check("stop_addr_mod", 256'(bus.tm_addr), 256'(63));
        load_group(63, 2'd0, 16'h0001, 0, 16'h0, 128'h0, 1'b0, 16'd0);
        go();
        wait_idle("wrap", 50);
        check("ptr_wrap", 256'(bus.tm_addr), 256'(0));

        // Illegal fence, then reset in the third LOAD beat
        load_group(0, 2'd3, 16'h0C00, 1, 16'h00FF, {16{8'h77}}, 1'b0, 16'd0);
        void'(sb.pop_back());
        go();
        found = 1'b0;
        for (int k = 0; k < 30 && !found; k++) begin
            @(negedge clk);
            if (bus.start != '0 && bus.load_cnt == 2'd2) found = 1'b1;
        end
        check("ill_reach_beat2", 256'(found), 256'(1));
        check("ill_err", 256'(bus.err), 256'(1));
        reset = 1'b1;
        @(negedge clk);
        check("abort_start", 256'(bus.start), 256'(0));
        check("abort_tm_addr", 256'(bus.tm_addr), 256'(0));
        check("abort_flags", 256'({bus.busy, bus.err, bus.frame_req}), 256'(0));
        check("abort_data", 256'({bus.insn_data, bus.init_r0_vect, bus.load_cnt}), 256'(0));
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_quiet", 256'({bus.start, bus.busy}), 256'(0));
        check("abort_sb", 256'(sb.size()), 256'(0));

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/task_dispatcher.md
TASK_DISPATCHER -- requirements
Module: task_dispatcher

Interface
REQ-001 SHALL have parameters: NUM_CORES, default 16, core count; TM_DEPTH, default 64, task-memory frames; LOAD_BEATS, default 4, beats per instruction frame; INSN_W, default 64, bits per beat; R0_W, default 8, per-core R0 width; IFN_W, default 8, instruction-frame-count width.
REQ-002 SHALL have ports:
clk  in  1  clock.
reset  in  1  synchronous, active-high.
enable  in  1  run permission, sampled only in FETCH.
tm_addr  out  clog2(TM_DEPTH)  task-memory read address.
tm_data  in  LOAD_BEATS*INSN_W  frame read data, valid one cycle after tm_addr.
ready  in  NUM_CORES  per-core idle.
start  out  NUM_CORES  per-core load strobe.
load_cnt  out  clog2(LOAD_BEATS)  current beat index.
insn_data  out  INSN_W  current beat payload.
init_r0_vect  out  NUM_CORES  R0-load mask.
init_r0  out  NUM_CORES*R0_W  R0 values.
frame_req  out  1  display-sync request.
frame_ack  in  1  display-sync acknowledge.
busy  out  1  state != FETCH.
err  out  1  sticky illegal-fence flag.
REQ-003 SHALL use reset reset, synchronous, active-high; clock clk.

Function
REQ-004 SHALL sequence states FETCH, DECODE, FENCE_WAIT, IF_FETCH, LOAD, DONE_WAIT, SYNC.
REQ-005 FETCH: if enable, go to DECODE next cycle with tm_addr = ptr; else hold.
REQ-006 DECODE SHALL register the control-frame fields: ifn, fence (NO=0, ACQ=1, REL=2), core_mask, init_r0_vect, init_r0, stop, stop_addr; fence code 3 SHALL be treated as NO and SHALL set err.
REQ-007 FENCE_WAIT: ACQ or REL SHALL wait for ready == all-ones; NO SHALL wait for (~ready & core_mask) == 0; on release, ptr advances.
REQ-008 On FENCE_WAIT release: if ifn == 0, go to SYNC when stop = 1, else FETCH; otherwise go to IF_FETCH.
REQ-009 IF_FETCH SHALL present ptr for one cycle, then LOAD.
REQ-010 LOAD SHALL last exactly LOAD_BEATS cycles with load_cnt = 0..LOAD_BEATS-1, insn_data = beat load_cnt of tm_data, and start = core_mask; start SHALL be 0 in all other states.
REQ-011 After the last beat: ptr advances, ifn decrements, state goes to DONE_WAIT.
REQ-012 DONE_WAIT SHALL ignore ready for its first cycle, then wait for (~ready & core_mask) == 0.
REQ-013 On DONE_WAIT release: ifn != 0 goes to IF_FETCH; ifn == 0 goes to SYNC when stop = 1 or fence = REL, else FETCH.
REQ-014 SYNC SHALL wait for ready == all-ones.
REQ-015 SYNC: when stop = 1, frame_req SHALL be held high until frame_ack is sampled high, then cleared.
REQ-016 SYNC exit: with stop = 1, ptr = stop_addr; then go to FETCH.
REQ-017 frame_ack outside SYNC SHALL be ignored.
REQ-018 ptr SHALL wrap from TM_DEPTH-1 to 0.
REQ-019 stop_addr >= TM_DEPTH SHALL be reduced modulo TM_DEPTH.
REQ-020 Deasserting enable SHALL take effect only at the next FETCH; an in-flight task group SHALL complete.

Reset
REQ-021 Reset SHALL force state FETCH and ptr = 0.
REQ-022 Reset SHALL clear start, load_cnt, insn_data, init_r0_vect, init_r0, frame_req, busy and err.
REQ-023 Reset asserted mid-LOAD or mid-SYNC SHALL abort immediately with no further start pulse.

Structure
REQ-024 A shared package SHALL hold the fence codes, the state enum, and the control-frame field offset functions of (NUM_CORES, R0_W, IFN_W).
REQ-025 Control-frame field extraction SHALL live in one combinational sub-module, td_cf_decode.

Verification
REQ-026 NO fence, core_mask 0x0003, ifn 2, stop 0, cores ready -> two 4-cycle start = 0x0003 bursts with load_cnt 0,1,2,3; ptr 0 -> 3.
REQ-027 ACQ fence with ready = 0xFFFE -> no start until core 0 becomes ready, then LOAD begins 2 cycles later.
REQ-028 Stop = 1, stop_addr 5, ifn 1 -> frame_req rises after cores idle; frame_ack pulse after 10 cycles -> next tm_addr = 5.
REQ-029 ptr at TM_DEPTH-1 with ifn 0, NO fence -> next fetch at address 0.
REQ-030 Fence code 3 -> err = 1 and sticky; behaves as NO; reset in the third LOAD cycle -> start = 0 next cycle, tm_addr = 0.
